// File: rtl/ls_reservation_station_if.sv
// Dispatch-to-reservation-station handshake and micro-op payload.
// The master (dispatch) offers a micro-op, and the slave (station) returns disp_ready.
interface ls_reservation_station_if #(
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned DATA_W = 16
);
    logic              disp_valid;
    logic              disp_ready;
    logic [DATA_W-1:0] disp_pc;
    logic [3:0]        disp_opcode;
    logic [DATA_W-1:0] disp_opr1;
    logic [DATA_W-1:0] disp_opr2;
    logic              disp_opr1_rdy;
    logic              disp_opr2_rdy;
    logic [TAG_W-1:0]  disp_opr1_tag;
    logic [TAG_W-1:0]  disp_opr2_tag;
    logic [TAG_W-1:0]  disp_rrf_dest;
    logic [1:0]        disp_cz;
    logic              disp_cmp;

    modport master (
        output disp_valid, disp_pc, disp_opcode, disp_opr1, disp_opr2,
               disp_opr1_rdy, disp_opr2_rdy, disp_opr1_tag, disp_opr2_tag,
               disp_rrf_dest, disp_cz, disp_cmp,
        input  disp_ready
    );

    modport slave (
        input  disp_valid, disp_pc, disp_opcode, disp_opr1, disp_opr2,
               disp_opr1_rdy, disp_opr2_rdy, disp_opr1_tag, disp_opr2_tag,
               disp_rrf_dest, disp_cz, disp_cmp,
        output disp_ready
    );
endinterface

// File: rtl/ls_reservation_station.sv
// In-order LW/SW reservation station feeding the LS0 pipe. It snoops the CDB and issues the head entry once the entry is ready.
// Optional macro LSRS_CDB_BYPASS_EN: the head may issue on the same-cycle CDB match, and that operand is taken from cdb_data.
module ls_reservation_station #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned DATA_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    ls_reservation_station_if.slave      disp,
    input  logic                         i_cdb_valid,
    input  logic [TAG_W-1:0]             i_cdb_tag,
    input  logic [DATA_W-1:0]            i_cdb_data,
    input  logic                         i_flush,
    output logic [DATA_W-1:0]            o_pc_out,
    output logic [3:0]                   o_opcode_out,
    output logic [DATA_W-1:0]            o_opr1_out,
    output logic [DATA_W-1:0]            o_opr2_out,
    output logic [TAG_W-1:0]             o_rrf_dest_out,
    output logic [1:0]                   o_cz_out,
    output logic                         o_cmp_out,
    output logic                         o_valid_out,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [3:0]        opcode;
        logic [DATA_W-1:0] opr1;
        logic [DATA_W-1:0] opr2;
        logic              v1;
        logic              v2;
        logic [TAG_W-1:0]  tag1;
        logic [TAG_W-1:0]  tag2;
        logic [TAG_W-1:0]  dest;
        logic [1:0]        cz;
        logic              cmp;
    } entry_t;

    entry_t             r_ent [DEPTH];
    logic [DEPTH-1:0]   r_occ;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_ready;

    entry_t             w_head;
    entry_t             w_new;
    logic               w_cap1;
    logic               w_cap2;
    logic               w_push;
    logic               w_issue;
    logic               w_h_rdy1;
    logic               w_h_rdy2;
    logic [DATA_W-1:0]  w_h_opr1;
    logic [DATA_W-1:0]  w_h_opr2;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [DEPTH-1:0]   w_wake1;
    logic [DEPTH-1:0]   w_wake2;

    assign disp.disp_ready = r_ready;
    assign o_count         = r_count;
    assign w_head          = r_ent[r_head];
    assign w_push          = disp.disp_valid && r_ready && !i_flush;

    // Build the new entry, capturing a same-cycle CDB broadcast for a missing operand
    always_comb begin
        w_cap1 = !disp.disp_opr1_rdy && i_cdb_valid && (disp.disp_opr1_tag == i_cdb_tag);
        w_cap2 = !disp.disp_opr2_rdy && i_cdb_valid && (disp.disp_opr2_tag == i_cdb_tag);

        w_new        = '0;
        w_new.pc     = disp.disp_pc;
        w_new.opcode = disp.disp_opcode;
        w_new.opr1   = w_cap1 ? i_cdb_data : disp.disp_opr1;
        w_new.opr2   = w_cap2 ? i_cdb_data : disp.disp_opr2;
        w_new.v1     = disp.disp_opr1_rdy || w_cap1;
        w_new.v2     = disp.disp_opr2_rdy || w_cap2;
        w_new.tag1   = disp.disp_opr1_tag;
        w_new.tag2   = disp.disp_opr2_tag;
        w_new.dest   = disp.disp_rrf_dest;
        w_new.cz     = disp.disp_cz;
        w_new.cmp    = disp.disp_cmp;
    end

    // CDB wakeup match for every occupied entry still waiting on an operand
    always_comb begin
        w_wake1 = '0;
        w_wake2 = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_wake1[i] = r_occ[i] && !r_ent[i].v1 && i_cdb_valid && (r_ent[i].tag1 == i_cdb_tag);
            w_wake2[i] = r_occ[i] && !r_ent[i].v2 && i_cdb_valid && (r_ent[i].tag2 == i_cdb_tag);
        end
    end

    // Head readiness and the operand values it would issue with
    always_comb begin
`ifdef LSRS_CDB_BYPASS_EN
        w_h_rdy1 = w_head.v1 || (i_cdb_valid && (w_head.tag1 == i_cdb_tag));
        w_h_rdy2 = w_head.v2 || (i_cdb_valid && (w_head.tag2 == i_cdb_tag));
        w_h_opr1 = w_head.v1 ? w_head.opr1 : i_cdb_data;
        w_h_opr2 = w_head.v2 ? w_head.opr2 : i_cdb_data;
`else
        w_h_rdy1 = w_head.v1;
        w_h_rdy2 = w_head.v2;
        w_h_opr1 = w_head.opr1;
        w_h_opr2 = w_head.opr2;
`endif
        w_issue = r_occ[r_head] && w_h_rdy1 && w_h_rdy2 && !i_flush;
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_issue})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Reset takes priority over flush, and flush takes priority over issue and dispatch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ          <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_ready        <= 1'b1;
            o_valid_out    <= 1'b0;
            o_pc_out       <= '0;
            o_opcode_out   <= '0;
            o_opr1_out     <= '0;
            o_opr2_out     <= '0;
            o_rrf_dest_out <= '0;
            o_cz_out       <= '0;
            o_cmp_out      <= 1'b0;
        end else if (i_flush) begin
            r_occ       <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_ready     <= 1'b1;
            o_valid_out <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (w_wake1[i]) begin
                    r_ent[i].opr1 <= i_cdb_data;
                    r_ent[i].v1   <= 1'b1;
                end
                if (w_wake2[i]) begin
                    r_ent[i].opr2 <= i_cdb_data;
                    r_ent[i].v2   <= 1'b1;
                end
            end

            if (w_push) begin
                r_ent[r_tail] <= w_new;
                r_occ[r_tail] <= 1'b1;
                r_tail        <= r_tail + PTR_W'(1);
            end

            if (w_issue) begin
                r_occ[r_head]  <= 1'b0;
                r_head         <= r_head + PTR_W'(1);
                o_valid_out    <= 1'b1;
                o_pc_out       <= w_head.pc;
                o_opcode_out   <= w_head.opcode;
                o_opr1_out     <= w_h_opr1;
                o_opr2_out     <= w_h_opr2;
                o_rrf_dest_out <= w_head.dest;
                o_cz_out       <= w_head.cz;
                o_cmp_out      <= w_head.cmp;
            end else begin
                o_valid_out <= 1'b0;
            end

            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != FULL_CNT);
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst) r_count <= FULL_CNT);
    a_no_write_full: assert property (@(posedge clk) disable iff (rst) !(w_push && (r_count == FULL_CNT)));
    a_count_occ: assert property (@(posedge clk) disable iff (rst) $countones(r_occ) == int'(r_count));

endmodule
